// File: rtl/usb_packet_feeder_if.sv
// usb_packet_feeder_if: pixel-stream input handshake and FX2-controller packet interface.
interface usb_packet_feeder_if;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        nframe;
    logic        send_out;
    logic        data_pulse;
    logic [15:0] data_in;
    modport master (output pix_data, pix_valid, data_pulse, input pix_ready, nframe, send_out, data_in);
    modport slave  (input pix_data, pix_valid, data_pulse, output pix_ready, nframe, send_out, data_in);
endinterface

// File: rtl/usb_packet_feeder.sv
// usb_packet_feeder: buffers DDR3 pixel words in a show-ahead FIFO and hands them to the FX2
// slave-FIFO controller one PKT_WORDS packet at a time, with a per-frame nframe restart pulse.
module usb_packet_feeder #(
    parameter int DEPTH       = 512,
    parameter int PKT_WORDS   = 256,
    parameter int FRAME_WORDS = 307200,
    parameter int NFRAME_CYC  = 4,
    localparam int AW         = $clog2(DEPTH),
    localparam int NW         = $clog2(NFRAME_CYC + 1)
) (
    input  logic                usb_clk,
    input  logic                rst_n,
    input  logic                frame_start,
    usb_packet_feeder_if.slave  bus,
    output logic                frame_done,
    output logic                underflow,
    output logic [AW:0]         fill
);
    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_WAIT, S_REQ, S_STREAM, S_GAP} state_t;

    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   PKT_LVL  = (AW + 1)'(PKT_WORDS);
    localparam logic [8:0]    PKT_LAST = 9'(PKT_WORDS - 1);
    localparam logic [18:0]   FRM_MAX  = 19'(FRAME_WORDS);
    localparam logic [NW-1:0] NF_LAST  = NW'(NFRAME_CYC - 1);

    state_t        state_q, state_d;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [8:0]    pkt_cnt_q, pkt_cnt_d;
    logic [18:0]   frame_cnt_q, frame_cnt_d;
    logic [NW-1:0] nf_cnt_q, nf_cnt_d;
    logic          underflow_q, underflow_d, frame_done_q, frame_done_d;
    logic          empty, full, push, pop_due, pop, pkt_avail;

    assign empty    = fill_q == '0;
    assign full     = fill_q == FULL_LVL;
    assign pkt_avail = fill_q >= PKT_LVL;
    // A push coinciding with frame_start would be discarded by the flush, so refuse it.
    assign bus.pix_ready = !full && state_q != S_FLUSH && !frame_start;
    assign push     = bus.pix_valid && bus.pix_ready;
    // Once a packet starts every one of its words is popped, even after data_pulse drops.
    assign pop_due  = (state_q == S_REQ && bus.data_pulse) || state_q == S_STREAM;
    assign pop      = pop_due && !empty;

    assign bus.nframe   = state_q == S_FLUSH;
    assign bus.send_out = state_q == S_REQ;
    assign bus.data_in  = empty ? 16'h0000 : mem[rd_ptr_q];
    assign frame_done   = frame_done_q;
    assign underflow    = underflow_q;
    assign fill         = fill_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fill_d       = fill_q + (AW + 1)'(push) - (AW + 1)'(pop);
        pkt_cnt_d    = pop_due ? pkt_cnt_q + 9'd1 : pkt_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        nf_cnt_d     = (state_q == S_FLUSH) ? nf_cnt_q + NW'(1) : '0;
        underflow_d  = underflow_q || (pop_due && empty);
        frame_done_d = 1'b0;
        case (state_q)
            S_FLUSH:  state_d = (nf_cnt_q == NF_LAST) ? S_WAIT : S_FLUSH;
            S_WAIT:   state_d = pkt_avail ? S_REQ : S_WAIT;
            S_REQ: if (bus.data_pulse) begin
                pkt_cnt_d = 9'd1;
                state_d   = S_STREAM;
            end
            S_STREAM: if (pkt_cnt_q == PKT_LAST) begin
                frame_cnt_d = (20'(frame_cnt_q) + 20'(PKT_WORDS) >= 20'(FRAME_WORDS)) ? FRM_MAX
                            : frame_cnt_q + 19'(PKT_WORDS);
                state_d     = S_GAP;
            end
            S_GAP: if (!bus.data_pulse) begin
                frame_done_d = frame_cnt_q == FRM_MAX;
                state_d      = frame_done_d ? S_IDLE : S_WAIT;
            end
            default: ;
        endcase
        if (frame_start) begin
            state_d      = S_FLUSH;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fill_d       = '0;
            pkt_cnt_d    = '0;
            frame_cnt_d  = '0;
            nf_cnt_d     = '0;
            underflow_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            pkt_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            nf_cnt_q     <= '0;
            underflow_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            pkt_cnt_q    <= pkt_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            nf_cnt_q     <= nf_cnt_d;
            underflow_q  <= underflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge usb_clk) begin
        if (push) mem[wr_ptr_q] <= bus.pix_data;
    end
endmodule

// File: tb/tb_usb_packet_feeder.sv
// tb_usb_packet_feeder: directed test of the packet feeder with FRAME_WORDS reduced to two packets.
module tb_usb_packet_feeder;
    logic       usb_clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_done, underflow;
    logic [9:0] fill;
    int         checks = 0;
    int         errors = 0;

    usb_packet_feeder_if bus ();

    usb_packet_feeder #(.DEPTH(512), .PKT_WORDS(256), .FRAME_WORDS(512), .NFRAME_CYC(4)) dut (
        .usb_clk(usb_clk), .rst_n(rst_n), .frame_start(frame_start), .bus(bus),
        .frame_done(frame_done), .underflow(underflow), .fill(fill)
    );

    always #5 usb_clk = ~usb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic push_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = 16'(base + i);
            tick();
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic do_frame_start();
        int n;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("nframe_rise", 32'(bus.nframe), 32'd1);
        check("flush_ready", 32'(bus.pix_ready), 32'd0);
        check("flush_fill", 32'(fill), 32'd0);
        check("flush_underflow", 32'(underflow), 32'd0);
        check("flush_send", 32'(bus.send_out), 32'd0);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n += int'(bus.nframe);
        end
        check("nframe_len", 32'(n), 32'd4);
    endtask

    task automatic run_packet(input int dp_cycles, input int base, input int valid_words);
        int w;
        w = 0;
        while (!bus.send_out && w < 2000) begin
            tick();
            w++;
        end
        check("send_out_wait", 32'(bus.send_out), 32'd1);
        bus.data_pulse = 1'b1;
        for (int i = 0; i < 256; i++) begin
            check("data_in", 32'(bus.data_in), (i < valid_words) ? 32'(16'(base + i)) : 32'h0);
            tick();
            if (i == 0) check("send_out_fall", 32'(bus.send_out), 32'd0);
            if (i + 1 == dp_cycles) bus.data_pulse = 1'b0;
        end
        bus.data_pulse = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.pix_data   = '0;
        bus.pix_valid  = 1'b0;
        bus.data_pulse = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_nframe", 32'(bus.nframe), 32'd0);
        check("rst_send", 32'(bus.send_out), 32'd0);
        check("rst_data", 32'(bus.data_in), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_ready", 32'(bus.pix_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // First packet of frame 1: words 0..299 in, 0..255 out
        do_frame_start();
        push_words(300, 0);
        check("fill_300", 32'(fill), 32'd300);
        run_packet(256, 0, 256);
        check("fill_44", 32'(fill), 32'd44);
        check("pkt1_underflow", 32'(underflow), 32'd0);
        tick();
        check("pkt1_no_done", 32'(frame_done), 32'd0);

        // Fill to capacity with no consumer
        push_words(468, 300);
        check("fill_full", 32'(fill), 32'd512);
        check("full_ready", 32'(bus.pix_ready), 32'd0);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 16'hdead;
        tick();
        bus.pix_valid = 1'b0;
        check("full_hold", 32'(fill), 32'd512);

        // Second packet completes the frame
        run_packet(256, 256, 256);
        check("pre_done", 32'(frame_done), 32'd0);
        tick();
        check("frame_done", 32'(frame_done), 32'd1);
        check("fill_256", 32'(fill), 32'd256);
        check("head_512", 32'(bus.data_in), 32'd512);
        tick();
        check("done_pulse", 32'(frame_done), 32'd0);
        tick();
        tick();
        check("idle_send", 32'(bus.send_out), 32'd0);

        // Underflow: packet forced with only 250 words buffered, data_pulse dropped early
        do_frame_start();
        push_words(250, 16'h1000);
        tick();
        tick();
        check("short_send", 32'(bus.send_out), 32'd0);
        force dut.pkt_avail = 1'b1;
        tick();
        release dut.pkt_avail;
        check("forced_send", 32'(bus.send_out), 32'd1);
        run_packet(10, 16'h1000, 250);
        check("underflow_set", 32'(underflow), 32'd1);
        check("uf_fill", 32'(fill), 32'd0);
        tick();
        check("underflow_sticky", 32'(underflow), 32'd1);

        // frame_start mid-packet
        push_words(300, 16'h2000);
        bus.data_pulse = 1'b1;
        repeat (100) tick();
        bus.data_pulse = 1'b0;
        do_frame_start();
        push_words(255, 16'h3000);
        check("fill_255", 32'(fill), 32'd255);
        check("send_255", 32'(bus.send_out), 32'd0);
        push_words(1, 16'h30ff);
        check("send_lat0", 32'(bus.send_out), 32'd0);
        tick();
        check("send_lat1", 32'(bus.send_out), 32'd1);
        check("head_3000", 32'(bus.data_in), 32'h3000);

        // Asynchronous reset mid-stream
        bus.data_pulse = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("arst_send", 32'(bus.send_out), 32'd0);
        check("arst_nframe", 32'(bus.nframe), 32'd0);
        check("arst_data", 32'(bus.data_in), 32'd0);
        check("arst_fill", 32'(fill), 32'd0);
        check("arst_underflow", 32'(underflow), 32'd0);
        check("arst_done", 32'(frame_done), 32'd0);
        bus.data_pulse = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_ready", 32'(bus.pix_ready), 32'd1);
        check("post_rst_send", 32'(bus.send_out), 32'd0);
        check("post_rst_nframe", 32'(bus.nframe), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_packet_feeder.md
Name: usb_packet_feeder

Overview:
- Upstream stage of the FX2 slave-FIFO USB controller.
- Buffers 16-bit pixel words arriving from the DDR3 read path in an internal FIFO.
- Issues the per-frame nframe restart pulse and requests one 256-word packet at a time with send_out.
- Drives data_in, one word per usb_clk, while the controller holds data_pulse high.

Parameters:
- DEPTH, 512: internal FIFO depth in words; power of two.
- PKT_WORDS, 256: words popped per packet.
- FRAME_WORDS, 307200: words per frame (640x480); must be a multiple of PKT_WORDS.
- NFRAME_CYC, 4: number of cycles nframe is held high.

Ports:
- usb_clk, input, 1: single clock for the whole block.
- rst_n, input, 1: asynchronous active-low reset.
- frame_start, input, 1: one-cycle pulse from the DDR3 read controller when a new frame begins.
- pix_data, input, 16: upstream pixel word.
- pix_valid, input, 1: pix_data is valid.
- pix_ready, output, 1: block can accept a word; a word is pushed when pix_valid and pix_ready are both high.
- nframe, output, 1: restart pulse to the USB controller.
- send_out, output, 1: packet request to the USB controller.
- data_pulse, input, 1: data window from the USB controller.
- data_in, output, 16: word presented to the USB controller.
- frame_done, output, 1: one-cycle pulse after the last packet of a frame.
- underflow, output, 1: sticky error flag.
- fill, output, log2(DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FIFO pointers and fill cleared; state goes to S_IDLE.
  - Outputs: nframe=0, send_out=0, data_in=0, frame_done=0, underflow=0, pix_ready=1.
- FIFO:
  - Synchronous and show-ahead: data_in always equals the head word while the FIFO is non-empty.
  - pix_ready = !full (fill < DEPTH).
  - Simultaneous push and pop leaves fill unchanged. Pointers wrap modulo DEPTH.
- frame_start:
  - Accepted in any state, including mid-packet. It aborts the current activity and enters S_FLUSH.
  - Clears the FIFO, pkt_cnt, frame_cnt and underflow.
  - pix_ready is 0 during S_FLUSH.
- S_IDLE:
  - All outputs low. Pushes are still accepted. Waits for frame_start.
- S_FLUSH:
  - nframe=1 for exactly NFRAME_CYC cycles, then the block moves to S_WAIT.
  - nframe falling lets the controller start its 256-word header phase.
- S_WAIT:
  - When fill >= PKT_WORDS, go to S_REQ.
  - send_out is registered, so it goes high on the first cycle of S_REQ.
- S_REQ:
  - send_out held at 1 until data_pulse is sampled high.
  - On that cycle send_out drops to 0, the block goes to S_STREAM and pkt_cnt is cleared.
  - The first pop happens in the same cycle data_pulse is sampled high.
- S_STREAM:
  - Each cycle data_pulse=1 and pkt_cnt < PKT_WORDS: pop one word and increment pkt_cnt.
  - The controller lowers data_pulse early. Any remaining pkt_cnt words are still popped one per cycle, so every packet consumes exactly PKT_WORDS words from the FIFO.
  - If a pop is due while the FIFO is empty:
    - data_in=16'h0000, no pointer move, pkt_cnt still increments;
    - underflow set to 1 and held until reset or frame_start.
  - When pkt_cnt reaches PKT_WORDS: add PKT_WORDS to frame_cnt, then go to S_GAP.
- S_GAP:
  - Wait for data_pulse=0.
  - Then, if frame_cnt == FRAME_WORDS: pulse frame_done for one cycle and go to S_IDLE.
  - Otherwise go to S_WAIT.
- data_pulse=1 outside S_REQ and S_STREAM is ignored.
- Arithmetic:
  - pkt_cnt is 9 bits.
  - frame_cnt is 19 bits and saturates at FRAME_WORDS.
  - fill never exceeds DEPTH.
- Latency:
  - From frame_start to nframe rising: 1 cycle.
  - From S_WAIT seeing fill >= PKT_WORDS to send_out rising: 1 cycle.

Test Plan:
- Reset with rst_n=0 mid-stream → all outputs 0 within the same cycle and fill=0; after release, pix_ready=1 and state is S_IDLE.
- frame_start, then 300 words pushed with pix_data counting 0..299, then data_pulse held 256 cycles after send_out → nframe high 4 cycles, data_in streams 0..255 in order, fill ends at 44, send_out falls on the first data_pulse cycle.
- 512 words pushed with no pop → pix_ready=0 at fill=512; an extra pix_valid is not accepted and fill stays at 512.
- Only 250 words loaded, then a packet is forced by asserting data_pulse in S_REQ → the last 6 words read 0x0000 and underflow=1.
- frame_start asserted at pkt_cnt=100 → FIFO flushed, nframe reissued, underflow cleared, send_out stays low until fill >= 256 again.
- With FRAME_WORDS=512 set for the test, two full packets → frame_done pulses exactly once, one cycle after data_pulse falls on packet 2, and the block returns to S_IDLE.
